aes128_round_sequencer: RTL and testbench

- Iterative AES-128 encryption controller that time-multiplexes one external round datapath over all ten rounds.
- The datapath is SubBytes, ShiftRows, MixColumns and AddRoundKey, with a MixColumns bypass for the final round.
- The block owns the state register, the on-the-fly key schedule and the round counter, plus valid/ready handshakes on both sides.
- It sits between the block-level cipher wrapper and the round datapath.

---
 rtl/aes128_round_sequencer_pkg.sv | 44 ++++
 rtl/aes128_round_sequencer_if.sv | 27 ++
 rtl/aes128_round_sequencer_key_step.sv | 34 +++
 rtl/aes128_round_sequencer.sv | 128 ++++++++++++
 tb/tb_aes128_round_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes128_round_sequencer_pkg.sv
// Shared AES-128 definitions for the round sequencer slice.
//   NR_AES128   : round count for a 128-bit key
//   seq_state_e : sequencer FSM states
//   RCON        : round constants, index 0 belongs to round 1
//   SBOX        : forward S-box, indexed by the input byte
//   get_byte    : byte k of a 128-bit block in FIPS-197 order (byte 0 in [127:120])
package aes_pkg;

  localparam int unsigned NR_AES128 = 10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_e;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] get_byte(input logic [127:0] blk, input int unsigned k);
    return blk[127 - 8*k -: 8];
  endfunction

endpackage

// File: rtl/aes128_round_sequencer_if.sv
// Job handshake between the cipher wrapper and the round sequencer.
//   in_valid/in_ready   : plaintext+key offer, accepted when both high
//   plaintext, key      : 128-bit job inputs, FIPS-197 byte order
//   out_valid/out_ready : ciphertext hand-off, completed when both high
//   ciphertext          : 128-bit result, FIPS-197 byte order
// master = cipher wrapper side, slave = sequencer side.
interface aes128_round_sequencer_if;

  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;

  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, ciphertext
  );

  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, ciphertext
  );

endinterface

// File: rtl/aes128_round_sequencer_key_step.sv
// One step of the AES-128 on-the-fly key schedule (combinational).
//   rk      : current round key (w0 = rk[127:96])
//   rcon    : round constant for the key being produced
//   rk_next : following round key
module aes128_key_step
  import aes_pkg::*;
(
  input  logic [127:0] rk,
  input  logic [7:0]   rcon,
  output logic [127:0] rk_next
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    w0 = rk[127:96];
    w1 = rk[95:64];
    w2 = rk[63:32];
    w3 = rk[31:0];
    // w3 holds bytes 12..15; RotWord moves byte 13 to the front, rcon lands on that byte
    t  = {SBOX[get_byte(rk, 13)] ^ rcon,
          SBOX[get_byte(rk, 14)],
          SBOX[get_byte(rk, 15)],
          SBOX[get_byte(rk, 12)]};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    rk_next = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes128_round_sequencer.sv
// Iterative AES-128 encryption controller. Owns the cipher state, the
// on-the-fly key schedule and the round counter; one external round
// datapath is reused for all ten rounds.
//   clk, rst_n : clock, synchronous active-low reset
//   job        : slave side of the plaintext/key in, ciphertext out handshake
//   busy       : high while a job is in RUN or DONE
//   dp_state   : state fed to the round datapath (0 outside RUN)
//   dp_key     : round key for the current round (0 outside RUN)
//   dp_last    : final round, datapath skips MixColumns
//   dp_result  : round datapath output
//   round_idx  : current round 1..NR, 0 outside RUN
module aes128_round_sequencer
  import aes_pkg::*;
#(
  parameter int unsigned NR = NR_AES128
) (
  input  logic                       clk,
  input  logic                       rst_n,
  aes128_round_sequencer_if.slave    job,
  output logic                       busy,
  output logic [127:0]               dp_state,
  output logic [127:0]               dp_key,
  output logic                       dp_last,
  input  logic [127:0]               dp_result,
  output logic [3:0]                 round_idx
);

  if (NR != NR_AES128) begin : g_bad_nr
    $fatal(1, "aes128_round_sequencer: only NR=10 (AES-128) is supported");
  end

  seq_state_e   fsm_q;
  logic [127:0] state_q;
  logic [127:0] rk_q;
  logic [127:0] ct_q;
  logic [3:0]   rnd_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         busy_q;
  logic         dp_last_q;

  logic         run;
  logic [3:0]   rcon_idx;
  logic [7:0]   rcon_cur;
  logic [127:0] rk_next;

  // rnd_q runs 1..NR in RUN; RCON[0] belongs to round 1
  always_comb begin
    run      = (fsm_q == RUN);
    rcon_idx = rnd_q - 4'd1;
    rcon_cur = '0;
    if (run && (rcon_idx < 4'(NR))) begin
      rcon_cur = RCON[rcon_idx];
    end
  end

  aes128_key_step u_key_step (
    .rk      (rk_q),
    .rcon    (rcon_cur),
    .rk_next (rk_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      rk_q        <= '0;
      ct_q        <= '0;
      rnd_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      dp_last_q   <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (job.in_valid && in_ready_q) begin
            // initial AddRoundKey is folded into the accept
            state_q    <= job.plaintext ^ job.key;
            rk_q       <= job.key;
            rnd_q      <= 4'd1;
            fsm_q      <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            dp_last_q  <= 1'b0;
          end
        end
        RUN: begin
          state_q <= dp_result;
          rk_q    <= rk_next;
          if (rnd_q == 4'(NR)) begin
            ct_q        <= dp_result;
            rnd_q       <= '0;
            fsm_q       <= DONE;
            out_valid_q <= 1'b1;
            dp_last_q   <= 1'b0;
          end else begin
            rnd_q     <= rnd_q + 4'd1;
            // registered so it is high exactly while rnd_q == NR
            dp_last_q <= ((rnd_q + 4'd1) == 4'(NR));
          end
        end
        DONE: begin
          if (job.out_ready) begin
            fsm_q       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          fsm_q <= IDLE;
        end
      endcase
    end
  end

  assign job.in_ready   = in_ready_q;
  assign job.out_valid  = out_valid_q;
  assign job.ciphertext = ct_q;

  assign busy      = busy_q;
  assign dp_last   = dp_last_q;
  assign round_idx = rnd_q;
  assign dp_state  = run ? state_q : '0;
  assign dp_key    = run ? rk_next : '0;

endmodule

// File: tb/tb_aes128_round_sequencer.sv
module tb_aes128_round_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         busy;
  logic [127:0] dp_state;
  logic [127:0] dp_key;
  logic         dp_last;
  logic [127:0] dp_result;
  logic [3:0]   round_idx;

  aes128_round_sequencer_if job_if ();

  aes128_round_sequencer #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .job       (job_if),
    .busy      (busy),
    .dp_state  (dp_state),
    .dp_key    (dp_key),
    .dp_last   (dp_last),
    .dp_result (dp_result),
    .round_idx (round_idx)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- AES arithmetic, built from GF(2^8) ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x};
    return d[15 - n -: 8];
  endfunction

  initial begin
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      inv = '0;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  // one full round on a 4x4 column-major byte matrix
  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   m [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        m[rw][c] = sb[st[127 - 8*(4*c + rw) -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        t[rw][c] = m[rw][(c + rw) % 4];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[0][c]; a1 = t[1][c]; a2 = t[2][c]; a3 = t[3][c];
        t[0][c] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[1][c] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[2][c] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[3][c] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        o[127 - 8*(4*c + rw) -: 8] = t[rw][c];
    return o ^ rk;
  endfunction

  // external round datapath
  always_comb dp_result = aes_round(dp_state, dp_key, dp_last);

  // ---------------- reference model ----------------
  logic [127:0] m_rk [11];
  logic [127:0] m_st [11];
  int           m_mode = 0;   // 0 waiting for a job, 1 computing, 2 holding result
  int           m_round = 0;
  logic [127:0] m_ct = '0;
  bit           chk_en = 1'b0;
  int unsigned  cyc = 0;
  int unsigned  n_acc = 0;
  int unsigned  acc_cyc [$];

  // whole-job trace: every round key and every intermediate state
  task automatic build_trace(input logic [127:0] pt, input logic [127:0] k_in);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k_in[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    m_st[0] = pt ^ k_in;
    for (int r = 1; r < 11; r++) m_st[r] = aes_round(m_st[r-1], m_rk[r], r == 10);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_mode = 0; m_round = 0; m_ct = '0; chk_en = 1'b1;
    end else if (m_mode == 0) begin
      if (job_if.in_valid) begin
        build_trace(job_if.plaintext, job_if.key);
        m_mode = 1; m_round = 1;
        n_acc++;
        acc_cyc.push_back(cyc);
      end
    end else if (m_mode == 1) begin
      if (m_round == 10) begin
        m_ct = m_st[10]; m_mode = 2; m_round = 0;
      end else begin
        m_round++;
      end
    end else begin
      if (job_if.out_ready) m_mode = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",   128'(job_if.in_ready),  128'(m_mode == 0));
      chk("out_valid",  128'(job_if.out_valid), 128'(m_mode == 2));
      chk("busy",       128'(busy),             128'(m_mode != 0));
      chk("round_idx",  128'(round_idx),        128'((m_mode == 1) ? m_round : 0));
      chk("dp_last",    128'(dp_last),          128'(m_mode == 1 && m_round == 10));
      chk("ciphertext", job_if.ciphertext,      m_ct);
      if (m_mode == 1) begin
        chk("dp_key",   dp_key,   m_rk[m_round]);
        chk("dp_state", dp_state, m_st[m_round - 1]);
      end else begin
        chk("dp_key_idle",   dp_key,   '0);
        chk("dp_state_idle", dp_state, '0);
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_job(input logic [127:0] pt, input logic [127:0] k_in,
                        input bit has_exp, input logic [127:0] exp_ct,
                        input bit chk_rk10, input bit poke, input bit noise,
                        input int hold, input string tag);
    int           n;
    bit           seen;
    logic [127:0] rk10;
    @(posedge clk); #2;
    job_if.in_valid  = 1'b1;
    job_if.plaintext = pt;
    job_if.key       = k_in;
    job_if.out_ready = 1'b0;
    @(posedge clk); #2;
    job_if.in_valid = 1'b0;
    n = 0; seen = 1'b0; rk10 = '0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (round_idx == 4'd10) rk10 = dp_key;
      if (job_if.out_valid) seen = 1'b1;
      if (poke && n == 4) begin
        job_if.in_valid = 1'b1; job_if.plaintext = rand128(); job_if.key = rand128();
      end
      if (poke && n == 5) job_if.in_valid = 1'b0;
      if (noise) job_if.out_ready = (n < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    chk({tag, "_latency"}, 128'(n), 128'(11));
    if (has_exp) chk({tag, "_ct"}, job_if.ciphertext, exp_ct);
    if (chk_rk10) chk({tag, "_rk10"}, rk10, RK10_B);
    repeat (hold) @(negedge clk);
    if (has_exp) chk({tag, "_ct_held"}, job_if.ciphertext, exp_ct);
    chk({tag, "_in_ready_held"}, 128'(job_if.in_ready), 128'(0));
    job_if.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_in_ready_after"}, 128'(job_if.in_ready), 128'(1));
    chk({tag, "_out_valid_after"}, 128'(job_if.out_valid), 128'(0));
    job_if.out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1);
  end

  initial begin
    int          n;
    int unsigned base;
    int unsigned dl;

    rst_n = 1'b0;
    job_if.in_valid  = 1'b0;
    job_if.plaintext = '0;
    job_if.key       = '0;
    job_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",   128'(job_if.in_ready),  128'(1));
    chk("rst_out_valid",  128'(job_if.out_valid), 128'(0));
    chk("rst_busy",       128'(busy),             128'(0));
    chk("rst_round_idx",  128'(round_idx),        128'(0));
    chk("rst_dp_last",    128'(dp_last),          128'(0));
    chk("rst_ciphertext", job_if.ciphertext,      '0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // App. B with round-10 key check and 20 cycles of backpressure
    do_job(PT_B, KEY_B, 1'b1, CT_B, 1'b1, 1'b0, 1'b0, 20, "appB");
    // App. C.1
    do_job(PT_C, KEY_C, 1'b1, CT_C, 1'b0, 1'b0, 1'b0, 0, "appC1");
    // in_valid with other data while running must be ignored
    do_job(PT_B, KEY_B, 1'b1, CT_B, 1'b0, 1'b1, 1'b0, 2, "busy_rej");

    // reset in round 5 abandons the job
    @(posedge clk); #2;
    job_if.in_valid = 1'b1; job_if.plaintext = PT_B; job_if.key = KEY_B;
    @(posedge clk); #2;
    job_if.in_valid = 1'b0;
    n = 0;
    while (round_idx != 4'd5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reset_reached_r5", 128'(round_idx), 128'(5));
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_reset_in_ready",  128'(job_if.in_ready),  128'(1));
    chk("mid_reset_out_valid", 128'(job_if.out_valid), 128'(0));
    chk("mid_reset_round_idx", 128'(round_idx),        128'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;
    do_job(PT_C, KEY_C, 1'b1, CT_C, 1'b0, 1'b0, 1'b0, 1, "post_reset");

    // back-to-back: in_valid held, fresh random data every cycle
    base = n_acc; dl = 0;
    @(posedge clk); #2;
    job_if.out_ready = 1'b1;
    job_if.in_valid  = 1'b1;
    job_if.plaintext = rand128(); job_if.key = rand128();
    n = 0;
    while (n < 80) begin
      @(posedge clk); #2;
      if (dp_last && round_idx == 4'd10) dl++;
      if (n_acc >= base + 4) break;
      job_if.plaintext = rand128(); job_if.key = rand128();
      n++;
    end
    job_if.in_valid = 1'b0;
    repeat (14) begin
      @(posedge clk); #2;
      if (dp_last && round_idx == 4'd10) dl++;
    end
    job_if.out_ready = 1'b0;
    chk("b2b_accepts", 128'(n_acc - base), 128'(4));
    chk("b2b_dp_last_pulses", 128'(dl), 128'(4));
    if (n_acc >= base + 4)
      for (int i = 1; i < 4; i++)
        chk("b2b_spacing", 128'(acc_cyc[base + i] - acc_cyc[base + i - 1]), 128'(12));

    // random jobs with random backpressure and out_ready noise while running
    for (int j = 0; j < 6; j++)
      do_job(rand128(), rand128(), 1'b0, '0, 1'b0, 1'b0, 1'b1, $urandom_range(0, 4), "rand");

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
